// File: rtl/decrypt.sv
// ---------------------------------------------------------------------------
// decrypt
// LWE decryption engine. Streams (a_i, s_i) element pairs, accumulates the
// inner product <a,s> mod q, subtracts it from the latched scalar b and
// rounds the difference to the nearest plaintext symbol mod t (half-up).
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a decryption, latches b_in (IDLE only)
//   abort      in   synchronous return to IDLE, drops any result
//   b_in       in   ciphertext scalar b
//   in_valid   in   a_elem / s_elem are valid
//   in_ready   out  block accepts an element pair (ACCUM state)
//   a_elem     in   ciphertext vector element a_i
//   s_elem     in   secret key element s_i
//   out_valid  out  plaintext holds a result
//   out_ready  in   consumer accepts the result
//   plaintext  out  decrypted symbol m
//   busy       out  state is not IDLE
// ---------------------------------------------------------------------------
module decrypt #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 10,
  parameter int DIM_WIDTH          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CIPHERTEXT_WIDTH-1:0] b_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0] a_elem,
  input  logic [CIPHERTEXT_WIDTH-1:0] s_elem,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PLAINTEXT_WIDTH-1:0]  plaintext,
  output logic                        busy
);

  localparam int CW = CIPHERTEXT_WIDTH;
  localparam int PW = PLAINTEXT_WIDTH;

  // Half of one plaintext step (q/(2t)); adding it before truncation turns
  // floor division into round-half-up.
  localparam logic [CW:0] HALF_STEP =
    (CW+1)'(CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS));
  localparam logic [DIM_WIDTH-1:0] LAST_CNT = DIM_WIDTH'(DIMENSION - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [CW-1:0]         r_acc;
  logic [CW-1:0]         r_b;
  logic [DIM_WIDTH-1:0]  r_cnt;
  logic [PW-1:0]         r_plaintext;
  logic                  r_outValid;

  logic [CW-1:0]         w_accNext;
  logic [CW-1:0]         w_bNext;
  logic [DIM_WIDTH-1:0]  w_cntNext;
  logic [PW-1:0]         w_plaintextNext;
  logic                  w_outValidNext;

  logic [2*CW-1:0]       w_fullProd;
  logic [CW-1:0]         w_prod;
  logic [CW-1:0]         w_accSum;
  logic [CW-1:0]         w_diff;
  logic [CW:0]           w_round;
  logic [PW-1:0]         w_symbol;

  // Datapath for the current beat. q is a power of two, so every "mod q"
  // is simply truncation to CW bits, and "mod t" after the shift is
  // truncation to PW bits.
  assign w_fullProd = a_elem * s_elem;
  assign w_prod     = CW'(w_fullProd);
  assign w_accSum   = r_acc + w_prod;
  assign w_diff     = r_b - w_accSum;
  assign w_round    = {1'b0, w_diff} + HALF_STEP;
  assign w_symbol   = PW'(w_round >> (CW - PW));

  assign in_ready  = (r_state == ACCUM);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_outValid;
  assign plaintext = r_plaintext;

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_plaintext <= '0;
      r_outValid  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_acc       <= w_accNext;
      r_b         <= w_bNext;
      r_cnt       <= w_cntNext;
      r_plaintext <= w_plaintextNext;
      r_outValid  <= w_outValidNext;
    end
  end

  // Next-state and next-value logic. abort overrides everything; the last
  // beat writes the rounded symbol using the accumulator value that
  // includes that beat's product.
  always_comb begin
    w_nextState     = r_state;
    w_accNext       = r_acc;
    w_bNext         = r_b;
    w_cntNext       = r_cnt;
    w_plaintextNext = r_plaintext;
    w_outValidNext  = r_outValid;

    if (abort) begin
      w_nextState    = IDLE;
      w_accNext      = '0;
      w_cntNext      = '0;
      w_outValidNext = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_bNext     = b_in;
            w_accNext   = '0;
            w_cntNext   = '0;
            w_nextState = ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            w_accNext = w_accSum;
            w_cntNext = r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              w_plaintextNext = w_symbol;
              w_outValidNext  = 1'b1;
              w_nextState     = OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            w_outValidNext = 1'b0;
            w_nextState    = IDLE;
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decrypt.sv
// ---------------------------------------------------------------------------
// tb_decrypt
// Self-checking bench for decrypt: directed cases from the decryption rules
// plus randomized ciphertexts, all compared against an arithmetic reference
// model of LWE decryption.
// ---------------------------------------------------------------------------
module tb_decrypt;

  localparam int PM  = 64;
  localparam int PW  = 6;
  localparam int CM  = 1024;
  localparam int CW  = 10;
  localparam int DIM = 10;
  localparam int DW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] b_in;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] a_elem;
  logic [CW-1:0] s_elem;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] plaintext;
  logic          busy;

  int testCount = 0;
  int failCount = 0;
  int aVec[DIM];
  int sVec[DIM];

  decrypt #(
    .PLAINTEXT_MODULUS (PM),
    .PLAINTEXT_WIDTH   (PW),
    .CIPHERTEXT_MODULUS(CM),
    .CIPHERTEXT_WIDTH  (CW),
    .DIMENSION         (DIM),
    .DIM_WIDTH         (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .b_in     (b_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_elem   (a_elem),
    .s_elem   (s_elem),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .plaintext(plaintext),
    .busy     (busy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Safety net so the run always ends even if something hangs
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference decryption: m = round_half_up((b - <a,s>) * t / q) mod t,
  // evaluated with integer arithmetic as floor((2*diff*t + q) / (2*q)).
  function automatic int refModel(input int b);
    int acc;
    int diff;
    acc = 0;
    for (int i = 0; i < DIM; i++)
      acc = (acc + (aVec[i] * sVec[i]) % CM) % CM;
    diff = (((b - acc) % CM) + CM) % CM;
    return ((2 * diff * PM + CM) / (2 * CM)) % PM;
  endfunction

  // Advance to just after the next rising edge
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic fillVectors(input int aVal, input int sVal);
    for (int i = 0; i < DIM; i++) begin
      aVec[i] = aVal;
      sVec[i] = sVal;
    end
  endtask

  // One full decryption. gapMode: 0 back-to-back, 1 alternate-cycle gaps,
  // 2 random gaps. holdCycles: cycles of out_ready=0 in OUTPUT, with a
  // stray start pulse and stray in_valid that must both be ignored.
  task automatic applyStimulus(input string name, input int b,
                               input int gapMode, input int holdCycles);
    int  expected;
    int  cycles;
    int  beat;
    bit  gap;
    expected = refModel(b);
    start = 1'b1;
    b_in  = CW'(b);
    stepClk();
    start = 1'b0;
    b_in  = CW'($urandom);
    checkOutput({name, " in_ready after start"}, 32'(in_ready), 1);
    checkOutput({name, " busy after start"}, 32'(busy), 1);
    cycles = 0;
    beat   = 0;
    while (beat < DIM) begin
      if (gapMode == 1)      gap = (cycles % 2 == 0);
      else if (gapMode == 2) gap = ($urandom_range(0, 2) == 0);
      else                   gap = 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        a_elem   = CW'($urandom);
        s_elem   = CW'($urandom);
      end else begin
        in_valid = 1'b1;
        a_elem   = CW'(aVec[beat]);
        s_elem   = CW'(sVec[beat]);
        beat++;
      end
      out_ready = (gapMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      checkOutput({name, " out_valid during accum"}, 32'(out_valid), 0);
      stepClk();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput({name, " out_valid after last beat"}, 32'(out_valid), 1);
    checkOutput({name, " plaintext"}, 32'(plaintext), 32'(expected));
    checkOutput({name, " in_ready in output"}, 32'(in_ready), 0);
    if (gapMode == 1)
      checkOutput({name, " cycles with gaps"}, 32'(cycles), 32'(2 * DIM));
    else if (gapMode == 0)
      checkOutput({name, " cycles back-to-back"}, 32'(cycles), 32'(DIM));
    for (int h = 0; h < holdCycles; h++) begin
      start    = (h == 1);
      in_valid = 1'($urandom_range(0, 1));
      a_elem   = CW'($urandom);
      stepClk();
      checkOutput({name, " out_valid held"}, 32'(out_valid), 1);
      checkOutput({name, " plaintext held"}, 32'(plaintext), 32'(expected));
      checkOutput({name, " in_ready held"}, 32'(in_ready), 0);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stepClk();
    out_ready = 1'b0;
    checkOutput({name, " out_valid after accept"}, 32'(out_valid), 0);
    checkOutput({name, " busy after accept"}, 32'(busy), 0);
    checkOutput({name, " plaintext kept"}, 32'(plaintext), 32'(expected));
  endtask

  // Start a run, feed 4 beats, then interrupt with reset or abort and
  // confirm the block recovers with a fresh b=80, a=0 run.
  task automatic interruptRun(input bit useReset);
    fillVectors(0, 0);
    for (int i = 0; i < DIM; i++) begin
      aVec[i] = int'($urandom_range(0, CM - 1));
      sVec[i] = int'($urandom_range(0, CM - 1));
    end
    start = 1'b1;
    b_in  = CW'($urandom);
    stepClk();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a_elem   = CW'(aVec[i]);
      s_elem   = CW'(sVec[i]);
      stepClk();
    end
    if (useReset) begin
      #1 rst_n = 1'b0;
      #1;
      checkOutput("reset mid out_valid", 32'(out_valid), 0);
      checkOutput("reset mid in_ready", 32'(in_ready), 0);
      checkOutput("reset mid busy", 32'(busy), 0);
      checkOutput("reset mid plaintext", 32'(plaintext), 0);
      #1 rst_n = 1'b1;
      in_valid = 1'b0;
    end else begin
      abort = 1'b1;
      stepClk();
      abort    = 1'b0;
      in_valid = 1'b0;
      checkOutput("abort mid busy", 32'(busy), 0);
      checkOutput("abort mid in_ready", 32'(in_ready), 0);
      checkOutput("abort mid out_valid", 32'(out_valid), 0);
    end
    stepClk();
    fillVectors(0, 5);
    applyStimulus(useReset ? "after reset" : "after abort", 80, 0, 0);
  endtask

  // Main sequence: reset, directed cases, interruptions, random runs
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    b_in      = '0;
    in_valid  = 1'b0;
    a_elem    = '0;
    s_elem    = '0;
    out_ready = 1'b0;
    #1;
    checkOutput("reset plaintext", 32'(plaintext), 0);
    checkOutput("reset out_valid", 32'(out_valid), 0);
    checkOutput("reset in_ready", 32'(in_ready), 0);
    checkOutput("reset busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stepClk();

    fillVectors(0, 5);
    applyStimulus("zero vector", 80, 0, 0);
    fillVectors(1, 1);
    applyStimulus("unit products", 122, 0, 0);
    fillVectors(0, 0);
    applyStimulus("round b=87", 87, 0, 0);
    applyStimulus("round b=72", 72, 0, 0);
    applyStimulus("round b=88", 88, 0, 0);
    applyStimulus("round b=1016 wrap", 1016, 0, 0);
    fillVectors(1023, 1);
    applyStimulus("acc wrap 1023", 0, 0, 0);
    fillVectors(1000, 3);
    applyStimulus("acc wrap 1000x3", 0, 1, 5);

    interruptRun(1'b1);
    interruptRun(1'b0);

    // abort during OUTPUT drops the result; abort beats start in IDLE
    fillVectors(7, 9);
    start = 1'b1;
    b_in  = CW'(500);
    stepClk();
    start    = 1'b0;
    in_valid = 1'b1;
    a_elem   = CW'(7);
    s_elem   = CW'(9);
    repeat (DIM) stepClk();
    in_valid = 1'b0;
    checkOutput("pre-abort plaintext", 32'(plaintext), 32'(refModel(500)));
    abort = 1'b1;
    stepClk();
    abort = 1'b0;
    checkOutput("abort output out_valid", 32'(out_valid), 0);
    checkOutput("abort output busy", 32'(busy), 0);
    start = 1'b1;
    abort = 1'b1;
    stepClk();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort beats start", 32'(busy), 0);

    for (int run = 0; run < 24; run++) begin
      for (int i = 0; i < DIM; i++) begin
        aVec[i] = int'($urandom_range(0, CM - 1));
        sVec[i] = int'($urandom_range(0, CM - 1));
      end
      applyStimulus($sformatf("random %0d", run), int'($urandom_range(0, CM - 1)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
